// File: rtl/mux_n_reg.sv
// rtl/mux_n_reg.sv - N-way operand select with registered output, stall/flush and select-error counting.
// Define MUXN_ONEHOT_EN to take sel as an N-bit one-hot vector instead of an encoded index.
module mux_n_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int ERR_W = 8,
  localparam int SEL_W = (N < 2) ? 1 : $clog2(N),
`ifdef MUXN_ONEHOT_EN
  localparam int SEL_IN_W = N
`else
  localparam int SEL_IN_W = SEL_W
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   W_in,
  input  logic [SEL_IN_W-1:0]  sel,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  output logic [WIDTH-1:0]     W_out,
  output logic                 out_valid,
  output logic                 sel_err,
  output logic [ERR_W-1:0]     err_cnt
);

  generate
    if (N < 2 || N > 16) begin : g_bad_n
      $error("mux_n_reg: N must be in 2..16");
    end
  endgenerate

  logic [N-1:0]     w_hit;
  logic             w_legal;
  logic [WIDTH-1:0] w_data;

  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic             r_err;
  logic [ERR_W-1:0] r_cnt;

  // Every select style reduces to a per-channel hit vector feeding an AND-OR mux.
  always_comb begin
    w_hit = '0;
`ifdef MUXN_ONEHOT_EN
    w_hit   = sel;
    w_legal = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
`else
    for (int k = 0; k < N; k++) begin
      w_hit[k] = (sel == SEL_W'(k));
    end
    w_legal = |w_hit;
`endif
    w_data = '0;
    for (int k = 0; k < N; k++) begin
      w_data = w_data | (W_in[k*WIDTH +: WIDTH] & {WIDTH{w_hit[k]}});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (stall) begin
      r_out   <= r_out;
      r_valid <= r_valid;
      r_err   <= r_err;
    end else if (in_valid) begin
      r_out   <= w_legal ? w_data : '0;
      r_valid <= 1'b1;
      r_err   <= ~w_legal;
      if (!w_legal && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end
  end

  assign W_out     = r_out;
  assign out_valid = r_valid;
  assign sel_err   = r_err;
  assign err_cnt   = r_cnt;

endmodule

// File: tb/tb_mux_n_reg.sv
// tb/tb_mux_n_reg.sv - directed self-checking bench for mux_n_reg (encoded and MUXN_ONEHOT_EN builds).
module tb_mux_n_reg;
`ifdef MUXN_ONEHOT_EN
  localparam int SA_W = 4;
  localparam int SB_W = 3;
  localparam logic [SB_W-1:0] BBAD = 3'b000;
`else
  localparam int SA_W = 2;
  localparam int SB_W = 2;
  localparam logic [SB_W-1:0] BBAD = 2'd3;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [127:0] a_w;  logic [SA_W-1:0] a_sel; logic a_iv, a_st, a_fl;
  logic [31:0] a_out; logic a_ov, a_se; logic [7:0] a_cnt;
  logic [95:0]  b_w;  logic [SB_W-1:0] b_sel; logic b_iv, b_st, b_fl;
  logic [31:0] b_out; logic b_ov, b_se; logic [7:0] b_cnt;
  logic [95:0]  c_w;  logic [SB_W-1:0] c_sel; logic c_iv, c_st, c_fl;
  logic [31:0] c_out; logic c_ov, c_se; logic [1:0] c_cnt;

  mux_n_reg #(.WIDTH(32), .N(4), .ERR_W(8)) u_a (
    .clk(clk), .rst(rst), .W_in(a_w), .sel(a_sel), .in_valid(a_iv), .stall(a_st), .flush(a_fl),
    .W_out(a_out), .out_valid(a_ov), .sel_err(a_se), .err_cnt(a_cnt));
  mux_n_reg #(.WIDTH(32), .N(3), .ERR_W(8)) u_b (
    .clk(clk), .rst(rst), .W_in(b_w), .sel(b_sel), .in_valid(b_iv), .stall(b_st), .flush(b_fl),
    .W_out(b_out), .out_valid(b_ov), .sel_err(b_se), .err_cnt(b_cnt));
  mux_n_reg #(.WIDTH(32), .N(3), .ERR_W(2)) u_c (
    .clk(clk), .rst(rst), .W_in(c_w), .sel(c_sel), .in_valid(c_iv), .stall(c_st), .flush(c_fl),
    .W_out(c_out), .out_valid(c_ov), .sel_err(c_se), .err_cnt(c_cnt));

  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SA_W-1:0] ea(input int k);
`ifdef MUXN_ONEHOT_EN
    ea = SA_W'(1) << k;
`else
    ea = SA_W'(k);
`endif
  endfunction

  function automatic logic [SB_W-1:0] eb(input int k);
`ifdef MUXN_ONEHOT_EN
    eb = SB_W'(1) << k;
`else
    eb = SB_W'(k);
`endif
  endfunction

  logic [31:0] cha [4];

  initial begin
    cha[0] = 32'h11111111; cha[1] = 32'h22222222; cha[2] = 32'h33333333; cha[3] = 32'h44444444;
    a_st = 0; a_fl = 0; b_st = 0; b_fl = 0; c_st = 0; c_fl = 0;
    b_iv = 0; c_iv = 0; b_sel = '0; c_sel = '0;
    b_w = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    c_w = b_w;

    // Reset with live-looking inputs: must be ignored.
    rst = 1; a_iv = 1; a_sel = ea(1);
    a_w = {$urandom, $urandom, $urandom, $urandom};
    tick(); tick();
    check("rst_wout", a_out, 32'h0);
    check("rst_valid", {31'b0, a_ov}, 32'h0);
    rst = 0; a_iv = 0;
    tick();
    check("idle_wout", a_out, 32'h0);
    check("idle_valid", {31'b0, a_ov}, 32'h0);
    check("idle_err", {31'b0, a_se}, 32'h0);
    check("idle_cnt", {24'b0, a_cnt}, 32'h0);

    // Back-to-back captures of every channel.
    a_w = {cha[3], cha[2], cha[1], cha[0]};
    a_iv = 1;
    for (int k = 0; k < 4; k++) begin
      a_sel = ea(k);
      tick();
      check($sformatf("sel%0d_wout", k), a_out, cha[k]);
      check($sformatf("sel%0d_valid", k), {31'b0, a_ov}, 32'h1);
    end

    // Stall holds, flush overrides stall.
    a_sel = ea(2);
    tick();
    check("pre_stall", a_out, 32'h33333333);
    a_st = 1; a_sel = ea(1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_wout", a_out, 32'h33333333);
      check("stall_valid", {31'b0, a_ov}, 32'h1);
    end
    a_fl = 1;
    tick();
    check("flush_wout", a_out, 32'h0);
    check("flush_valid", {31'b0, a_ov}, 32'h0);
    a_st = 0; a_fl = 0;

    // Idle after a capture keeps data but drops valid.
    a_sel = ea(3);
    tick();
    check("cap3_wout", a_out, 32'h44444444);
    a_iv = 0;
    tick();
    check("idle_hold_wout", a_out, 32'h44444444);
    check("idle_hold_valid", {31'b0, a_ov}, 32'h0);

`ifdef MUXN_ONEHOT_EN
    a_iv = 1; a_sel = 4'b0100;
    tick();
    check("oh_ch2", a_out, 32'h33333333);
    check("oh_ch2_err", {31'b0, a_se}, 32'h0);
    a_sel = 4'b0110;
    tick();
    check("oh_multi_wout", a_out, 32'h0);
    check("oh_multi_err", {31'b0, a_se}, 32'h1);
    check("oh_multi_valid", {31'b0, a_ov}, 32'h1);
    check("oh_multi_cnt", {24'b0, a_cnt}, 32'h1);
    a_sel = 4'b0000;
    tick();
    check("oh_zero_err", {31'b0, a_se}, 32'h1);
    check("oh_zero_cnt", {24'b0, a_cnt}, 32'h2);
    a_iv = 0;
`else
    check("a_cnt_clean", {24'b0, a_cnt}, 32'h0);
`endif

    // Illegal select on N=3.
    b_iv = 1; b_sel = BBAD;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("bad_wout", b_out, 32'h0);
      check("bad_err", {31'b0, b_se}, 32'h1);
      check("bad_valid", {31'b0, b_ov}, 32'h1);
      check($sformatf("bad_cnt%0d", k), {24'b0, b_cnt}, k);
    end
    b_sel = eb(1);
    tick();
    check("good_wout", b_out, 32'hBBBBBBBB);
    check("good_err", {31'b0, b_se}, 32'h0);
    check("good_cnt", {24'b0, b_cnt}, 32'h3);
    b_st = 1; b_sel = BBAD;
    tick();
    check("stall_bad_cnt", {24'b0, b_cnt}, 32'h3);
    check("stall_bad_err", {31'b0, b_se}, 32'h0);
    b_fl = 1;
    tick();
    check("flush_cnt_hold", {24'b0, b_cnt}, 32'h3);
    check("flush_err", {31'b0, b_se}, 32'h0);
    b_st = 0; b_fl = 0; b_iv = 0;

    // Saturation with ERR_W=2.
    c_iv = 1; c_sel = BBAD;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("sat_cnt%0d", k), {30'b0, c_cnt}, (k < 3) ? k : 3);
    end
    c_iv = 0;

    // Reset overrides stall.
    c_st = 1; a_st = 1; rst = 1;
    tick();
    check("rst_sat_cnt", {30'b0, c_cnt}, 32'h0);
    check("rst_stall_b_cnt", {24'b0, b_cnt}, 32'h0);
    check("rst_stall_a_wout", a_out, 32'h0);
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
